// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage Beta core.
// Looks at the instruction sitting in decode and the loads in flight in EXEC
// and MEM. From these it selects the IR sources for IF->DEC and DEC->EXEC,
// the fetch PC source and the front-end stall. It resolves load-use
// interlocks, branch/jump annulment, illegal opcodes and external interrupts.
// A two-state FSM masks interrupts for a few cycles after exception entry.
// A saturating counter records how many cycles were lost to load-use stalls.
module hazard_ctrl #(
    parameter int XCPT_HOLD = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ir_dec,
    input  logic             zr_dec,
    input  logic             super_dec,
    input  logic [14:0]      ir_exec,
    input  logic             op_ld_or_ldr_exec,
    input  logic [14:0]      ir_mem,
    input  logic             op_ld_or_ldr_mem,
    input  logic             irq,
    output logic [1:0]       ir_src_if,
    output logic [1:0]       ir_src_dec,
    output logic             stall,
    output logic [2:0]       pc_sel,
    output logic             irq_ack,
    output logic [CNT_W-1:0] stall_cnt
);

    // IR mux encodings shared by both IR source selects
    localparam logic [1:0] IR_SRC_DATA   = 2'd0;
    localparam logic [1:0] IR_SRC_NOP    = 2'd1;
    localparam logic [1:0] IR_SRC_EXCEPT = 2'd2;

    // fetch PC source encodings
    localparam logic [2:0] PC_PLUS4  = 3'd0;
    localparam logic [2:0] PC_BRANCH = 3'd1;
    localparam logic [2:0] PC_JUMP   = 3'd2;
    localparam logic [2:0] PC_ILLOP  = 3'd3;
    localparam logic [2:0] PC_XADDR  = 3'd4;
    localparam logic [2:0] PC_RESET  = 3'd5;

    // opcodes that get individual treatment
    localparam logic [5:0] OPC_ST  = 6'b011001;
    localparam logic [5:0] OPC_JMP = 6'b011011;
    localparam logic [5:0] OPC_BEQ = 6'b011100;
    localparam logic [5:0] OPC_BNE = 6'b011101;
    localparam logic [5:0] OPC_LDR = 6'b011111;

    // hold counter is 3 bits wide, enough for the 1..7 mask window
    localparam logic [2:0] HOLD_INIT = 3'(XCPT_HOLD);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_XHOLD = 1'b1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [2:0]       hold_reg;
    logic [2:0]       hold_next;
    logic             dec_valid_reg;
    logic             dec_valid_next;
    logic [CNT_W-1:0] stall_cnt_reg;

    // decode-stage fields
    logic [5:0] opc;
    logic [4:0] rc;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [4:0] dest_exec;
    logic [4:0] dest_mem;

    assign opc       = ir_dec[31:26];
    assign rc        = ir_dec[25:21];
    assign ra        = ir_dec[20:16];
    assign rb        = ir_dec[15:11];
    assign dest_exec = ir_exec[14:10];
    assign dest_mem  = ir_mem[14:10];

    // low instruction bits and the non-destination parts of the EXEC/MEM
    // fields do not affect sequencing
    logic unused_bits;
    assign unused_bits = ^{ir_dec[10:0], ir_exec[9:0], ir_mem[9:0]};

    logic illegal;
    logic use_ra;
    logic use_rb;
    logic use_rc;
    logic taken;
    logic taken_jmp;

    // opcode classification: legality, which register fields are read, branch outcome
    always_comb begin
        illegal = 1'b0;
        case (opc[5:4])
            2'b00: illegal = 1'b1;
            2'b01: illegal = !(opc[3:0] inside {4'b1000, 4'b1001, 4'b1011,
                                                4'b1100, 4'b1101, 4'b1111});
            default: illegal = (!opc[3] && (opc[2:0] inside {3'b010, 3'b011, 3'b111}))
                               || (opc[3:0] == 4'b1111);
        endcase
        use_ra    = !illegal && (opc != OPC_LDR);
        use_rb    = !illegal && (opc[5:4] == 2'b10);
        use_rc    = !illegal && (opc == OPC_ST);
        taken_jmp = (opc == OPC_JMP);
        taken     = taken_jmp
                    || ((opc == OPC_BEQ) && zr_dec)
                    || ((opc == OPC_BNE) && !zr_dec);
    end

    // per-source interlock check against the loads in EXEC and MEM
    logic [4:0] src_reg [3];
    logic [2:0] src_use;
    logic [2:0] src_hit;
    logic       load_use;

    assign src_reg[0] = ra;
    assign src_reg[1] = rb;
    assign src_reg[2] = rc;
    assign src_use    = {use_rc, use_rb, use_ra};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] && (src_reg[gi] != 5'd31)
                                 && ((op_ld_or_ldr_exec && (src_reg[gi] == dest_exec))
                                  || (op_ld_or_ldr_mem  && (src_reg[gi] == dest_mem)));
        end
    endgenerate

    assign load_use = |src_hit;

    // priority resolution (illegal > irq > load-use > taken > normal) and FSM next state
    always_comb begin
        ir_src_if  = IR_SRC_DATA;
        ir_src_dec = IR_SRC_DATA;
        pc_sel     = PC_PLUS4;
        stall      = 1'b0;
        irq_ack    = 1'b0;
        state_next = state_reg;
        hold_next  = hold_reg;

        // mask window counts down on its own; leaving it when it expires
        if (state_reg == ST_XHOLD) begin
            if (hold_reg <= 3'd1) begin
                state_next = ST_RUN;
                hold_next  = 3'd0;
            end else begin
                hold_next = hold_reg - 3'd1;
            end
        end

        // bubbles in decode never trigger any action
        if (dec_valid_reg) begin
            if (illegal) begin
                ir_src_dec = IR_SRC_EXCEPT;
                ir_src_if  = IR_SRC_NOP;
                pc_sel     = PC_ILLOP;
                state_next = ST_XHOLD;
                hold_next  = HOLD_INIT;
            end else if (irq && !super_dec && (state_reg == ST_RUN)) begin
                // replaces the decode instruction even if it would have stalled
                ir_src_dec = IR_SRC_EXCEPT;
                ir_src_if  = IR_SRC_NOP;
                pc_sel     = PC_XADDR;
                irq_ack    = 1'b1;
                state_next = ST_XHOLD;
                hold_next  = HOLD_INIT;
            end else if (load_use) begin
                // operands are stale, so a branch here waits until the stall clears
                stall      = 1'b1;
                ir_src_dec = IR_SRC_NOP;
            end else if (taken) begin
                ir_src_if = IR_SRC_NOP;
                pc_sel    = taken_jmp ? PC_JUMP : PC_BRANCH;
            end
        end

        // reset overrides everything in the same cycle
        if (rst) begin
            ir_src_if  = IR_SRC_NOP;
            ir_src_dec = IR_SRC_NOP;
            pc_sel     = PC_RESET;
            stall      = 1'b0;
            irq_ack    = 1'b0;
            state_next = ST_RUN;
            hold_next  = 3'd0;
        end
    end

    // decode holds a real instruction unless a bubble or annul was fed in
    assign dec_valid_next = stall ? dec_valid_reg : (ir_src_if == IR_SRC_DATA);

    // state, mask window, decode-valid flag and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            hold_reg      <= 3'd0;
            dec_valid_reg <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            dec_valid_reg <= dec_valid_next;
            if (stall && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;

endmodule
